regfile_writeback_queue: RTL and testbench
==========================================

// Module: regfile_writeback_queue
// PURPOSE
//  Drives the single register-file write port (write_reg/write_data/write_enable).
//  Buffers completed results from two producers, ALU and load unit, in an in-order queue.
//  Retires one result per cycle into the register file.
//  Forwards still-queued results to the two decode-stage read ports.
// PARAMETERS
//  DEPTH       4   queue entries; power of two, >=2
//  XLEN        32  data width
//  RADDR_W     5   register address width (32 architectural regs)
// PORTS
//  clk          in   1        system clock; all state updates on posedge
//  rst          in   1        synchronous, active-high reset
//  alu_valid    in   1        ALU result offered
//  alu_rd       in   RADDR_W  ALU destination register
//  alu_data     in   XLEN     ALU result
//  alu_ready    out  1        ALU result accepted this cycle
//  mem_valid    in   1        load result offered
//  mem_rd       in   RADDR_W  load destination register
//  mem_data     in   XLEN     load result
//  mem_ready    out  1        load result accepted this cycle
//  port_busy    in   1        write port owned by another agent this cycle; no retire
//  write_reg    out  RADDR_W  regfile write address (head entry)
//  write_data   out  XLEN     regfile write data (head entry)
//  write_enable out  1        regfile write strobe
//  fwd_addr1/2  in   RADDR_W  decode read addresses to check
//  fwd_hit1/2   out  1        queued value pending for fwd_addrN
//  fwd_data1/2  out  XLEN     youngest queued value for fwd_addrN
//  occupancy    out  $clog2(DEPTH)+1  valid entries
// BEHAVIOUR
//  - Reset: queue emptied, pointers/count=0; write_enable=0, fwd_hit*=0, occupancy=0;
//    write_reg/write_data=0. Reset mid-operation discards all pending entries, no write issued.
//  - Retire (pop): write_enable = !empty && !port_busy, combinational from head.
//    write_reg/write_data = head entry, or 0 when empty. Pop on the same edge the regfile writes.
//  - space = (count<DEPTH) || write_enable; a pop frees a slot for a same-cycle push.
//  - Arbitration, one push per cycle, fixed priority ALU > MEM:
//    alu_ready = space; mem_ready = space && !alu_valid. Transfer = valid && ready.
//  - Destination 0: handshake completes (ready asserted), but nothing is enqueued;
//    count unchanged.
//  - Latency: result pushed at edge k -> write_enable can first assert in cycle k..k+1;
//    regfile updated at edge k+1 if queue was empty and port free.
//  - Simultaneous push+pop: count unchanged; push on full allowed only with pop.
//  - Pointers wrap modulo DEPTH; count saturates nowhere (guarded by space).
//  - Forwarding is combinational over all valid entries, including head being retired.
//    fwd_data = youngest matching entry; fwd_addr=0 never hits. Same-cycle incoming
//    alu/mem data is NOT forwarded.
//  - Order: entries retire strictly in push order; duplicate rd entries are all written.
// STRUCTURE
//  - Shared header cpu_defs.vh: XLEN, RADDR_W, REG_ZERO constant.
//  - Sub-module wb_fwd_lookup: youngest-match priority search over DEPTH {valid,rd,data};
//    instantiated twice (ports 1 and 2).
//  - Storage: DEPTH x {rd,data} flops plus per-entry valid; rd/wr pointers RADDR-independent.
// TESTING
//  1. rst mid-stream with 3 entries queued -> next cycle occupancy=0, write_enable=0, fwd_hit*=0.
//  2. alu {rd=5,0xAAAA} and mem {rd=6,0xBBBB} same cycle -> alu accepted, mem_ready=0;
//     mem accepted next cycle; regfile writes x5 then x6.
//  3. port_busy=1 for 6 cycles, alu pushes rd=1..4 -> occupancy=4, alu_ready=0 on 5th;
//     release -> writes x1..x4 in order, one per cycle.
//  4. Queue {rd=7,0x11},{rd=7,0x22}, fwd_addr1=7 -> fwd_hit1=1, fwd_data1=0x22;
//     fwd_addr2=0 -> fwd_hit2=0.
//  5. alu push rd=0 data=0xDEAD -> alu_ready=1, occupancy stays 0, no write_enable.
//  6. Full queue, port free, alu push -> push accepted and head retired same edge; occupancy stays 4.

Source files
------------

// File: rtl/regfile_writeback_queue_pkg.sv
// Shared constants for the writeback queue slice.
// Default geometry and the hard-wired zero register.
package regfile_writeback_queue_pkg;

  localparam int XLEN_D    = 32;
  localparam int RADDR_W_D = 5;
  localparam int DEPTH_D   = 4;

  localparam logic [RADDR_W_D-1:0] REG_ZERO = '0;

  // Writes to x0 are architecturally dropped.
  function automatic logic is_zero_reg(
    input logic [RADDR_W_D-1:0] rd
  );
    return rd == REG_ZERO;
  endfunction

endpackage

// File: rtl/regfile_writeback_queue_fwd.sv
// Youngest-match search over queued {valid,rd,data}.
// Ports: valid/rd/data entries, head pointer, addr in; hit/value out.
module wb_fwd_lookup
  import regfile_writeback_queue_pkg::*;
#(
  parameter int DEPTH   = DEPTH_D,
  parameter int XLEN    = XLEN_D,
  parameter int RADDR_W = RADDR_W_D
) (
  input  logic [DEPTH-1:0]              valid,
  input  logic [DEPTH-1:0][RADDR_W-1:0] rd,
  input  logic [DEPTH-1:0][XLEN-1:0]    data,
  input  logic [$clog2(DEPTH)-1:0]      head,
  input  logic [RADDR_W-1:0]            addr,
  output logic                          hit,
  output logic [XLEN-1:0]               value
);

  localparam int PW = $clog2(DEPTH);

  // Walk oldest to youngest from the head, so the
  // last match seen is the youngest one.
  always_comb begin
    logic [PW-1:0] idx;
    hit   = 1'b0;
    value = '0;
    idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (valid[idx] && rd[idx] == addr
          && addr != '0) begin
        hit   = 1'b1;
        value = data[idx];
      end
    end
  end

endmodule

// File: rtl/regfile_writeback_queue.sv
// In-order ALU/load result queue driving the regfile write port.
// Ports: alu_*/mem_* producers, port_busy, write_*, fwd_*, occupancy.
module regfile_writeback_queue
  import regfile_writeback_queue_pkg::*;
#(
  parameter int DEPTH   = DEPTH_D,
  parameter int XLEN    = XLEN_D,
  parameter int RADDR_W = RADDR_W_D
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [RADDR_W-1:0]       alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [RADDR_W-1:0]       mem_rd,
  input  logic [XLEN-1:0]          mem_data,
  output logic                     mem_ready,
  input  logic                     port_busy,
  output logic [RADDR_W-1:0]       write_reg,
  output logic [XLEN-1:0]          write_data,
  output logic                     write_enable,
  input  logic [RADDR_W-1:0]       fwd_addr1,
  output logic                     fwd_hit1,
  output logic [XLEN-1:0]          fwd_data1,
  input  logic [RADDR_W-1:0]       fwd_addr2,
  output logic                     fwd_hit2,
  output logic [XLEN-1:0]          fwd_data2,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DEPTH-1:0]              valid_q;
  logic [DEPTH-1:0][RADDR_W-1:0] rd_q;
  logic [DEPTH-1:0][XLEN-1:0]    data_q;
  logic [PW-1:0]                 rd_ptr;
  logic [PW-1:0]                 wr_ptr;
  logic [CW-1:0]                 count;

  logic               empty;
  logic               space;
  logic               alu_xfer;
  logic               mem_xfer;
  logic               push;
  logic               pop;
  logic [RADDR_W-1:0] in_rd;
  logic [XLEN-1:0]    in_data;

  assign empty = (count == '0);

  // Reset cycle never writes; pending work is dropped.
  assign write_enable = !empty && !port_busy && !rst;
  assign pop          = write_enable;
  assign write_reg    = empty ? '0 : rd_q[rd_ptr];
  assign write_data   = empty ? '0 : data_q[rd_ptr];

  // A same-edge pop frees the slot a push needs.
  assign space     = (count < FULL) || write_enable;
  assign alu_ready = space;
  assign mem_ready = space && !alu_valid;
  assign alu_xfer  = alu_valid && alu_ready;
  assign mem_xfer  = mem_valid && mem_ready;

  assign in_rd   = alu_xfer ? alu_rd : mem_rd;
  assign in_data = alu_xfer ? alu_data : mem_data;

  // x0 results complete the handshake but are not kept.
  assign push = (alu_xfer || mem_xfer)
             && !is_zero_reg(RADDR_W_D'(in_rd));

  assign occupancy = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
    end else begin
      if (pop) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PW'(1);
      end
      // Placed after the pop so a full push+pop on the
      // same slot leaves it valid.
      if (push) begin
        valid_q[wr_ptr] <= 1'b1;
        rd_q[wr_ptr]    <= in_rd;
        data_q[wr_ptr]  <= in_data;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  wb_fwd_lookup #(
    .DEPTH(DEPTH), .XLEN(XLEN), .RADDR_W(RADDR_W)
  ) u_fwd1 (
    .valid(valid_q), .rd(rd_q), .data(data_q),
    .head(rd_ptr), .addr(fwd_addr1),
    .hit(fwd_hit1), .value(fwd_data1)
  );

  wb_fwd_lookup #(
    .DEPTH(DEPTH), .XLEN(XLEN), .RADDR_W(RADDR_W)
  ) u_fwd2 (
    .valid(valid_q), .rd(rd_q), .data(data_q),
    .head(rd_ptr), .addr(fwd_addr2),
    .hit(fwd_hit2), .value(fwd_data2)
  );

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue.
// Logs regfile writes and checks against hand-computed values.
module tb_regfile_writeback_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid, port_busy;
  logic [4:0]  alu_rd, mem_rd, fwd_addr1, fwd_addr2;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        write_enable;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
  logic [2:0]  occupancy;

  int n_checks = 0;
  int n_fails  = 0;

  int log_rd[$];
  int log_d[$];

  regfile_writeback_queue dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd),
    .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd),
    .mem_data(mem_data), .mem_ready(mem_ready),
    .port_busy(port_busy),
    .write_reg(write_reg), .write_data(write_data),
    .write_enable(write_enable),
    .fwd_addr1(fwd_addr1), .fwd_hit1(fwd_hit1),
    .fwd_data1(fwd_data1),
    .fwd_addr2(fwd_addr2), .fwd_hit2(fwd_hit2),
    .fwd_data2(fwd_data2),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (write_enable === 1'b1) begin
      log_rd.push_back(int'(write_reg));
      log_d.push_back(int'(write_data));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic alu_push(input logic [4:0] rd,
                          input logic [31:0] d);
    alu_valid = 1'b1;
    alu_rd    = rd;
    alu_data  = d;
    tick();
    alu_valid = 1'b0;
  endtask

  task automatic drain();
    port_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (occupancy == 3'd0) break;
      tick();
    end
    check("drain_empty", 32'(occupancy), 32'd0);
  endtask

  task automatic check_log(input string tag,
                           input int idx,
                           input int rd,
                           input int d);
    int lr, ld;
    lr = (idx < log_rd.size()) ? log_rd[idx] : -1;
    ld = (idx < log_d.size()) ? log_d[idx] : -1;
    check({tag, "_rd"}, 32'(lr), 32'(rd));
    check({tag, "_data"}, 32'(ld), 32'(d));
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 1'b0; mem_valid = 1'b0;
    port_busy = 1'b0;
    alu_rd = '0; mem_rd = '0;
    alu_data = '0; mem_data = '0;
    fwd_addr1 = '0; fwd_addr2 = '0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_we", 32'(write_enable), 32'd0);
    check("rst_hit1", 32'(fwd_hit1), 32'd0);
    check("rst_hit2", 32'(fwd_hit2), 32'd0);
    check("rst_wreg", 32'(write_reg), 32'd0);
    check("rst_wdata", write_data, 32'd0);

    // ALU beats MEM in the same cycle
    log_rd.delete(); log_d.delete();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hAAAA;
    mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 32'hBBBB;
    #1;
    check("arb_alu_ready", 32'(alu_ready), 32'd1);
    check("arb_mem_ready", 32'(mem_ready), 32'd0);
    tick();
    alu_valid = 1'b0;
    #1;
    check("arb_mem_ready2", 32'(mem_ready), 32'd1);
    check("arb_we", 32'(write_enable), 32'd1);
    check("arb_wreg5", 32'(write_reg), 32'd5);
    tick();
    mem_valid = 1'b0;
    check("arb_wreg6", 32'(write_reg), 32'd6);
    check("arb_occ", 32'(occupancy), 32'd1);
    tick();
    check("arb_log_n", 32'(log_rd.size()), 32'd2);
    check_log("arb_w0", 0, 5, 32'hAAAA);
    check_log("arb_w1", 1, 6, 32'hBBBB);

    // busy port backs the queue up, then drains in order
    port_busy = 1'b1;
    for (int i = 1; i <= 4; i++)
      alu_push(5'(i), 32'h100 + 32'(i));
    check("busy_occ4", 32'(occupancy), 32'd4);
    check("busy_we", 32'(write_enable), 32'd0);
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h9;
    #1;
    check("busy_alu_ready", 32'(alu_ready), 32'd0);
    alu_valid = 1'b0;
    tick(); tick();
    check("busy_hold_occ", 32'(occupancy), 32'd4);
    log_rd.delete(); log_d.delete();
    port_busy = 1'b0;
    #1;
    check("rel_we", 32'(write_enable), 32'd1);
    check("rel_wreg", 32'(write_reg), 32'd1);
    for (int i = 3; i >= 0; i--) begin
      tick();
      check("rel_occ", 32'(occupancy), 32'(i));
    end
    check("rel_log_n", 32'(log_rd.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check_log("rel_w", i, i + 1, 32'h100 + i + 1);

    // reset with entries queued
    port_busy = 1'b1;
    alu_push(5'd20, 32'h20);
    alu_push(5'd21, 32'h21);
    alu_push(5'd22, 32'h22);
    fwd_addr1 = 5'd21; fwd_addr2 = 5'd22;
    #1;
    check("mid_occ3", 32'(occupancy), 32'd3);
    check("mid_hit1", 32'(fwd_hit1), 32'd1);
    log_rd.delete(); log_d.delete();
    rst = 1'b1; port_busy = 1'b0;
    tick();
    rst = 1'b0;
    check("mid_rst_occ", 32'(occupancy), 32'd0);
    check("mid_rst_we", 32'(write_enable), 32'd0);
    check("mid_rst_hit1", 32'(fwd_hit1), 32'd0);
    check("mid_rst_hit2", 32'(fwd_hit2), 32'd0);
    check("mid_rst_nowrite", 32'(log_rd.size()), 32'd0);

    // youngest-match forwarding, x0 never hits
    port_busy = 1'b1;
    alu_push(5'd7, 32'h11);
    alu_push(5'd7, 32'h22);
    alu_push(5'd3, 32'h33);
    fwd_addr1 = 5'd7; fwd_addr2 = 5'd0;
    #1;
    check("fwd_hit1", 32'(fwd_hit1), 32'd1);
    check("fwd_data1", fwd_data1, 32'h22);
    check("fwd_x0_hit2", 32'(fwd_hit2), 32'd0);
    fwd_addr2 = 5'd3;
    #1;
    check("fwd_hit2", 32'(fwd_hit2), 32'd1);
    check("fwd_data2", fwd_data2, 32'h33);
    fwd_addr2 = 5'd8;
    #1;
    check("fwd_miss2", 32'(fwd_hit2), 32'd0);
    drain();

    // incoming data is not forwarded until queued
    port_busy = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    fwd_addr1 = 5'd9;
    #1;
    check("inflight_hit", 32'(fwd_hit1), 32'd0);
    tick();
    alu_valid = 1'b0;
    check("queued_hit", 32'(fwd_hit1), 32'd1);
    check("queued_data", fwd_data1, 32'h99);
    drain();

    // x0 destination: accepted, not kept
    port_busy = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
    fwd_addr1 = 5'd0;
    #1;
    check("x0_ready", 32'(alu_ready), 32'd1);
    tick();
    alu_valid = 1'b0;
    check("x0_occ", 32'(occupancy), 32'd0);
    check("x0_we", 32'(write_enable), 32'd0);

    // full queue: push and retire on the same edge
    port_busy = 1'b1;
    for (int i = 0; i < 4; i++)
      alu_push(5'(10 + i), 32'hA0 + 32'(i));
    log_rd.delete(); log_d.delete();
    port_busy = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd14; alu_data = 32'hA4;
    #1;
    check("full_ready", 32'(alu_ready), 32'd1);
    check("full_we", 32'(write_enable), 32'd1);
    check("full_wreg", 32'(write_reg), 32'd10);
    tick();
    alu_valid = 1'b0;
    check("full_occ", 32'(occupancy), 32'd4);
    check("full_wreg2", 32'(write_reg), 32'd11);
    drain();
    check("full_log_n", 32'(log_rd.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      check_log("full_w", i, 10 + i, 32'hA0 + i);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
